// File: rtl/rx_pkg.sv
// Shared definitions for the receive buffer: status bit positions, word width
// and the latched per-frame payload.
package rx_pkg;

  localparam int unsigned RX_WORD_W = 12;

  localparam int unsigned ST_EMPTY  = 7;
  localparam int unsigned ST_FULL   = 6;
  localparam int unsigned ST_OVF    = 5;
  localparam int unsigned ST_CRC    = 4;
  localparam int unsigned ST_CNT_HI = 3;
  localparam int unsigned ST_CNT_LO = 0;

  localparam int unsigned ID_W   = 8;
  localparam int unsigned CMD_W  = 8;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [CMD_W-1:0]  command;
    logic [DATA_W-1:0] data_field;
    logic              crc_err;
  } frame_t;

endpackage

// File: rtl/rx_buffer_if.sv
// Decoder/APB-side bundle of the receive buffer: decoder strobes in,
// register-file values out, read strobe back.
interface rx_buffer_if #(
  parameter int unsigned WORDWIDTH = rx_pkg::RX_WORD_W
) ();

  logic                 word_valid_rx;
  logic [WORDWIDTH-1:0] word_rx;
  logic                 frame_done_rx;
  logic [7:0]           id_rx;
  logic [7:0]           command_rx;
  logic [15:0]          data_field_rx;
  logic                 crc_err_rx;
  logic                 flush_rx;
  logic                 read_enable_rx;

  logic [WORDWIDTH-1:0] reg_receive_rx;
  logic [7:0]           reg_id_rx;
  logic [7:0]           reg_command_rx;
  logic [15:0]          reg_data_field_rx;
  logic [7:0]           reg_status_rx;

  modport master (
    output word_valid_rx, word_rx, frame_done_rx, id_rx, command_rx,
           data_field_rx, crc_err_rx, flush_rx, read_enable_rx,
    input  reg_receive_rx, reg_id_rx, reg_command_rx, reg_data_field_rx,
           reg_status_rx
  );

  modport slave (
    input  word_valid_rx, word_rx, frame_done_rx, id_rx, command_rx,
           data_field_rx, crc_err_rx, flush_rx, read_enable_rx,
    output reg_receive_rx, reg_id_rx, reg_command_rx, reg_data_field_rx,
           reg_status_rx
  );

endinterface

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with flush; head reads 0 when empty. DEPTH must be a
// power of two so the pointers wrap naturally.
module rx_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 12,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_en, wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr_en && !rd_en) begin
        count_d = count_q + CNT_W'(1);
      end else if (rd_en && !wr_en) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rx_buffer.sv
// Receive buffer: word FIFO, pop edge detector, sticky overflow, frame
// latch and status word for the APB receive register file.
module rx_buffer
  import rx_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WORDWIDTH = RX_WORD_W
) (
  input logic        PCLK_rx,
  input logic        PRESETn_rx,
  rx_buffer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             re_q, re_d;
  logic             armed_q, armed_d;
  logic             pop_q, pop_d;
  logic             ovf_q, ovf_d;
  frame_t           frame_q, frame_d;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic [7:0]       status_c;

  rx_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORDWIDTH)
  ) u_fifo (
    .clk   (PCLK_rx),
    .rst_n (PRESETn_rx),
    .push  (bus.word_valid_rx),
    .pop   (pop_q),
    .flush (bus.flush_rx),
    .din   (bus.word_rx),
    .head  (bus.reg_receive_rx),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // armed_q masks the first sample after reset so a level already high at
  // release is not mistaken for a rising edge.
  always_comb begin
    re_d    = bus.read_enable_rx;
    armed_d = 1'b1;
    pop_d   = armed_q & bus.read_enable_rx & ~re_q;

    ovf_d = ovf_q;
    if (bus.flush_rx) begin
      ovf_d = 1'b0;
    end else if (bus.word_valid_rx && full && !pop_q) begin
      ovf_d = 1'b1;
    end

    frame_d = frame_q;
    if (bus.frame_done_rx) begin
      frame_d.id         = bus.id_rx;
      frame_d.command    = bus.command_rx;
      frame_d.data_field = bus.data_field_rx;
      frame_d.crc_err    = bus.crc_err_rx;
    end
  end

  always_ff @(posedge PCLK_rx or negedge PRESETn_rx) begin
    if (!PRESETn_rx) begin
      re_q    <= 1'b0;
      armed_q <= 1'b0;
      pop_q   <= 1'b0;
      ovf_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      re_q    <= re_d;
      armed_q <= armed_d;
      pop_q   <= pop_d;
      ovf_q   <= ovf_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    status_c                      = '0;
    status_c[ST_EMPTY]            = empty;
    status_c[ST_FULL]             = full;
    status_c[ST_OVF]              = ovf_q;
    status_c[ST_CRC]              = frame_q.crc_err;
    status_c[ST_CNT_HI:ST_CNT_LO] = 4'(count);
  end

  assign bus.reg_status_rx     = status_c;
  assign bus.reg_id_rx         = frame_q.id;
  assign bus.reg_command_rx    = frame_q.command;
  assign bus.reg_data_field_rx = frame_q.data_field;

endmodule

// File: tb/tb_rx_buffer.sv
// Self-checking bench for rx_buffer: directed scenarios plus a random run,
// all checked against a queue-based model of the receive buffer.
module tb_rx_buffer;

  localparam int unsigned DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_buffer_if #(.WORDWIDTH(12)) rx_if ();

  rx_buffer #(
    .DEPTH     (DEPTH),
    .WORDWIDTH (12)
  ) dut (
    .PCLK_rx    (clk),
    .PRESETn_rx (rst_n),
    .bus        (rx_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_q[$];
  bit          m_ovf;
  bit          m_crc;
  logic [7:0]  m_id;
  logic [7:0]  m_cmd;
  logic [15:0] m_data;
  bit          m_re_prev;
  bit          m_pop_due;

  // After reset the read strobe counts as already high: only a fresh rise pops.
  function automatic void model_reset();
    m_q.delete();
    m_ovf     = 1'b0;
    m_crc     = 1'b0;
    m_id      = '0;
    m_cmd     = '0;
    m_data    = '0;
    m_re_prev = 1'b1;
    m_pop_due = 1'b0;
  endfunction

  // One rising clock edge: a rise sampled now pops on the following edge.
  function automatic void model_step();
    bit do_pop;
    do_pop    = m_pop_due;
    m_pop_due = rx_if.read_enable_rx && !m_re_prev;
    m_re_prev = rx_if.read_enable_rx;
    if (rx_if.frame_done_rx) begin
      m_id   = rx_if.id_rx;
      m_cmd  = rx_if.command_rx;
      m_data = rx_if.data_field_rx;
      m_crc  = rx_if.crc_err_rx;
    end
    if (rx_if.flush_rx) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (do_pop && m_q.size() > 0) void'(m_q.pop_front());
      if (rx_if.word_valid_rx) begin
        if (m_q.size() < DEPTH) m_q.push_back(int'(rx_if.word_rx));
        else m_ovf = 1'b1;
      end
    end
  endfunction

  function automatic logic [7:0] exp_status();
    logic [7:0] s;
    s      = '0;
    s[7]   = (m_q.size() == 0);
    s[6]   = (m_q.size() == DEPTH);
    s[5]   = m_ovf;
    s[4]   = m_crc;
    s[3:0] = 4'(m_q.size());
    return s;
  endfunction

  function automatic logic [11:0] exp_head();
    if (m_q.size() == 0) return 12'h000;
    return 12'(m_q[0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    rx_if.word_valid_rx = 1'b0;
    rx_if.frame_done_rx = 1'b0;
    rx_if.flush_rx      = 1'b0;
  endtask

  task automatic push_word(input logic [11:0] w);
    rx_if.word_valid_rx = 1'b1;
    rx_if.word_rx       = w;
    tick();
  endtask

  task automatic pop_edge();
    rx_if.read_enable_rx = 1'b1;
    tick();
    rx_if.read_enable_rx = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if (rx_if.reg_status_rx !== 8'h80) begin
      errors++; $display("FAIL reset_status got %h exp 80", rx_if.reg_status_rx);
    end
    checks++;
    if (rx_if.reg_receive_rx !== 12'h000) begin
      errors++; $display("FAIL reset_head got %h exp 000", rx_if.reg_receive_rx);
    end
    checks++;
    if ({rx_if.reg_id_rx, rx_if.reg_command_rx, rx_if.reg_data_field_rx} !== 32'h0) begin
      errors++; $display("FAIL reset_frame got %h %h %h exp 0", rx_if.reg_id_rx,
                         rx_if.reg_command_rx, rx_if.reg_data_field_rx);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (rx_if.reg_status_rx !== 8'h80) begin
      errors++; $display("FAIL release_status got %h exp 80", rx_if.reg_status_rx);
    end
  endtask

  task automatic test_single_pop();
    push_word(12'hA5C);
    checks++;
    if (rx_if.reg_status_rx !== 8'h01 || rx_if.reg_receive_rx !== 12'hA5C) begin
      errors++; $display("FAIL push_one got %h/%h exp 01/a5c",
                         rx_if.reg_status_rx, rx_if.reg_receive_rx);
    end
    rx_if.read_enable_rx = 1'b1;
    tick();
    checks++;
    if (rx_if.reg_status_rx !== 8'h01) begin
      errors++; $display("FAIL pop_latency got %h exp 01", rx_if.reg_status_rx);
    end
    tick();
    tick();
    rx_if.read_enable_rx = 1'b0;
    tick();
    checks++;
    if (rx_if.reg_status_rx !== 8'h80 || rx_if.reg_receive_rx !== 12'h000) begin
      errors++; $display("FAIL pop_one got %h/%h exp 80/000",
                         rx_if.reg_status_rx, rx_if.reg_receive_rx);
    end
    push_word(12'h111);
    push_word(12'h222);
    rx_if.read_enable_rx = 1'b1;
    repeat (5) tick();
    rx_if.read_enable_rx = 1'b0;
    tick();
    checks++;
    if (rx_if.reg_status_rx !== 8'h01 || rx_if.reg_receive_rx !== 12'h222) begin
      errors++; $display("FAIL held_level got %h/%h exp 01/222",
                         rx_if.reg_status_rx, rx_if.reg_receive_rx);
    end
    pop_edge();
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) push_word(12'(i));
    checks++;
    if (rx_if.reg_status_rx !== 8'h48) begin
      errors++; $display("FAIL fill8 got %h exp 48", rx_if.reg_status_rx);
    end
    push_word(12'h009);
    checks++;
    if (rx_if.reg_status_rx !== 8'h68) begin
      errors++; $display("FAIL overflow got %h exp 68", rx_if.reg_status_rx);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (rx_if.reg_receive_rx !== 12'(i)) begin
        errors++; $display("FAIL pop_order[%0d] got %h exp %h", i, rx_if.reg_receive_rx, 12'(i));
      end
      pop_edge();
    end
    checks++;
    if (rx_if.reg_status_rx !== 8'hA0) begin
      errors++; $display("FAIL drain_ovf got %h exp a0", rx_if.reg_status_rx);
    end
    rx_if.flush_rx = 1'b1;
    tick();
  endtask

  task automatic test_full_push_pop();
    logic [11:0] last;
    for (int i = 1; i <= 8; i++) push_word(12'(i));
    rx_if.read_enable_rx = 1'b1;
    tick();
    rx_if.read_enable_rx = 1'b0;
    push_word(12'h00F);
    checks++;
    if (rx_if.reg_status_rx !== 8'h48 || rx_if.reg_receive_rx !== 12'h002) begin
      errors++; $display("FAIL full_push_pop got %h/%h exp 48/002",
                         rx_if.reg_status_rx, rx_if.reg_receive_rx);
    end
    last = 12'h000;
    for (int i = 0; i < 8; i++) begin
      last = rx_if.reg_receive_rx;
      pop_edge();
    end
    checks++;
    if (last !== 12'h00F || rx_if.reg_status_rx !== 8'h80) begin
      errors++; $display("FAIL full_last got %h/%h exp 00f/80", last, rx_if.reg_status_rx);
    end
  endtask

  task automatic test_frame();
    rx_if.frame_done_rx = 1'b1;
    rx_if.id_rx         = 8'h3C;
    rx_if.command_rx    = 8'h81;
    rx_if.data_field_rx = 16'hBEEF;
    rx_if.crc_err_rx    = 1'b1;
    tick();
    rx_if.id_rx = 8'h00; rx_if.command_rx = 8'h00; rx_if.data_field_rx = 16'h0;
    rx_if.crc_err_rx = 1'b0;
    checks++;
    if (rx_if.reg_id_rx !== 8'h3C || rx_if.reg_command_rx !== 8'h81 ||
        rx_if.reg_data_field_rx !== 16'hBEEF || rx_if.reg_status_rx !== 8'h90) begin
      errors++; $display("FAIL frame_load got %h %h %h st %h exp 3c 81 beef st 90",
                         rx_if.reg_id_rx, rx_if.reg_command_rx,
                         rx_if.reg_data_field_rx, rx_if.reg_status_rx);
    end
    tick();
    checks++;
    if (rx_if.reg_id_rx !== 8'h3C || rx_if.reg_status_rx !== 8'h90) begin
      errors++; $display("FAIL frame_hold got %h st %h exp 3c st 90",
                         rx_if.reg_id_rx, rx_if.reg_status_rx);
    end
    rx_if.frame_done_rx = 1'b1;
    rx_if.id_rx         = 8'h55;
    rx_if.command_rx    = 8'h12;
    rx_if.data_field_rx = 16'h1234;
    rx_if.crc_err_rx    = 1'b0;
    tick();
    checks++;
    if (rx_if.reg_id_rx !== 8'h55 || rx_if.reg_command_rx !== 8'h12 ||
        rx_if.reg_data_field_rx !== 16'h1234 || rx_if.reg_status_rx !== 8'h80) begin
      errors++; $display("FAIL frame_crc_clear got %h %h %h st %h exp 55 12 1234 st 80",
                         rx_if.reg_id_rx, rx_if.reg_command_rx,
                         rx_if.reg_data_field_rx, rx_if.reg_status_rx);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) push_word(12'(16 + i));
    repeat (3) pop_edge();
    checks++;
    if (rx_if.reg_status_rx !== 8'h25) begin
      errors++; $display("FAIL pre_flush got %h exp 25", rx_if.reg_status_rx);
    end
    rx_if.flush_rx      = 1'b1;
    rx_if.word_valid_rx = 1'b1;
    rx_if.word_rx       = 12'h777;
    tick();
    checks++;
    if (rx_if.reg_status_rx !== 8'h80 || rx_if.reg_receive_rx !== 12'h000) begin
      errors++; $display("FAIL flush got %h/%h exp 80/000",
                         rx_if.reg_status_rx, rx_if.reg_receive_rx);
    end
    tick();
    checks++;
    if (rx_if.reg_status_rx !== 8'h80 || rx_if.reg_id_rx !== 8'h55) begin
      errors++; $display("FAIL post_flush got %h id %h exp 80 id 55",
                         rx_if.reg_status_rx, rx_if.reg_id_rx);
    end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) push_word(12'(32 + i));
    rx_if.read_enable_rx = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rx_if.reg_status_rx !== 8'h80 || rx_if.reg_id_rx !== 8'h00) begin
      errors++; $display("FAIL async_reset got %h id %h exp 80 id 00",
                         rx_if.reg_status_rx, rx_if.reg_id_rx);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    push_word(12'h0A1);
    push_word(12'h0A2);
    tick();
    tick();
    checks++;
    if (rx_if.reg_status_rx !== 8'h02 || rx_if.reg_receive_rx !== 12'h0A1) begin
      errors++; $display("FAIL no_pop_after_reset got %h/%h exp 02/0a1",
                         rx_if.reg_status_rx, rx_if.reg_receive_rx);
    end
    rx_if.read_enable_rx = 1'b0;
    tick();
    pop_edge();
    checks++;
    if (rx_if.reg_status_rx !== 8'h01 || rx_if.reg_receive_rx !== 12'h0A2) begin
      errors++; $display("FAIL pop_after_reset got %h/%h exp 01/0a2",
                         rx_if.reg_status_rx, rx_if.reg_receive_rx);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rx_if.word_valid_rx = ($urandom_range(0, 9) < 6);
      rx_if.word_rx       = 12'($urandom);
      rx_if.frame_done_rx = ($urandom_range(0, 7) == 0);
      rx_if.id_rx         = 8'($urandom);
      rx_if.command_rx    = 8'($urandom);
      rx_if.data_field_rx = 16'($urandom);
      rx_if.crc_err_rx    = 1'($urandom);
      rx_if.flush_rx      = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 2) == 0) rx_if.read_enable_rx = ~rx_if.read_enable_rx;
      tick();
      checks++;
      if (rx_if.reg_status_rx !== exp_status() || rx_if.reg_receive_rx !== exp_head()) begin
        errors++; $display("FAIL rand_fifo[%0d] got %h/%h exp %h/%h", n, rx_if.reg_status_rx,
                           rx_if.reg_receive_rx, exp_status(), exp_head());
      end
      checks++;
      if (rx_if.reg_id_rx !== m_id || rx_if.reg_command_rx !== m_cmd ||
          rx_if.reg_data_field_rx !== m_data) begin
        errors++; $display("FAIL rand_frame[%0d] got %h %h %h exp %h %h %h", n,
                           rx_if.reg_id_rx, rx_if.reg_command_rx, rx_if.reg_data_field_rx,
                           m_id, m_cmd, m_data);
      end
    end
  endtask

  initial begin
    rx_if.word_valid_rx  = 1'b0;
    rx_if.word_rx        = '0;
    rx_if.frame_done_rx  = 1'b0;
    rx_if.id_rx          = '0;
    rx_if.command_rx     = '0;
    rx_if.data_field_rx  = '0;
    rx_if.crc_err_rx     = 1'b0;
    rx_if.flush_rx       = 1'b0;
    rx_if.read_enable_rx = 1'b0;
    model_reset();
    tick();
    tick();
    test_reset();
    test_single_pop();
    test_fill_overflow();
    test_full_push_pop();
    test_frame();
    test_flush();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
